// File: rtl/fir_mac_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fir_mac_scheduler
//
// Time-multiplexed FIR engine controller. Each accepted sample is written into
// a circular history buffer. One shared multiply-accumulate then walks all TAPS
// products. Coefficients come from an external registered ROM. The accumulator
// is shifted right arithmetically by SHIFT, clamped to the signed DATA_W range,
// and presented on out_sample with a one-cycle out_valid pulse.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset (aborts any pass and
//                clears the history)
//   in_valid     in_sample is offered
//   in_ready     a sample is accepted this cycle if in_valid is high
//                (IDLE or DONE)
//   in_sample    signed input sample
//   coef_addr    coefficient ROM address; holds its last value outside RUN
//   coef_data    signed coefficient, valid one cycle after coef_addr
//   busy         high in every state except IDLE
//   out_valid    one-cycle pulse; out_sample carries a new result
//   out_sample   signed saturated output, held until the next out_valid
//
// Timing: the accept edge is T0. Taps 0..TAPS-1 are issued on the TAPS cycles
// that follow. The last product then needs three more cycles to reach the
// accumulator: one for the ROM register and two for the multiply and add
// stages. The DONE cycle therefore starts at edge T0+TAPS+3. A downstream
// register captures out_valid at edge T0+TAPS+4. A sample offered during DONE
// is accepted at that same edge, so the engine takes one sample every TAPS+4
// cycles.
// -----------------------------------------------------------------------------
module fir_mac_scheduler #(
  parameter int TAPS     = 201,
  parameter int MULTBITS = 32,
  parameter int SHIFT    = 15,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_sample,
  output logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_sample
);

  localparam int AW        = $clog2(TAPS);
  localparam int ACCUBITS  = MULTBITS + $clog2(TAPS);
  // ROM register plus the multiply and accumulate stages behind the last issue.
  localparam int DRAIN_CYC = 3;

  localparam logic [AW-1:0]             LAST_TAP   = AW'(TAPS - 1);
  localparam logic [1:0]                LAST_DRAIN = 2'(DRAIN_CYC - 1);
  localparam logic signed [ACCUBITS-1:0] SAT_MAX   = ACCUBITS'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACCUBITS-1:0] SAT_MIN   = ACCUBITS'(-(2 ** (DATA_W - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The arithmetic shift truncates toward negative infinity. After the shift
  // the value is only clamped; no rounding is applied.
  function automatic logic signed [DATA_W-1:0] sat_shift(
    input logic signed [ACCUBITS-1:0] v
  );
    logic signed [ACCUBITS-1:0] sh;
    sh = v >>> SHIFT;
    if (sh > SAT_MAX) begin
      sat_shift = SAT_MAX[DATA_W-1:0];
    end else if (sh < SAT_MIN) begin
      sat_shift = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_shift = sh[DATA_W-1:0];
    end
  endfunction

  // Control state
  state_t                      state_q, state_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]               coef_addr_q, coef_addr_d;
  logic [1:0]                  drain_cnt_q, drain_cnt_d;
  logic                        vld_p0_q, vld_p0_d;
  logic                        vld_p1_q, vld_p1_d;
  logic                        vld_p2_q, vld_p2_d;

  // Data state
  logic signed [DATA_W-1:0]    hist_q [TAPS];
  logic signed [DATA_W-1:0]    hist_d [TAPS];
  logic signed [DATA_W-1:0]    smp_p0_q, smp_p0_d;
  logic signed [DATA_W-1:0]    smp_p1_q, smp_p1_d;
  logic signed [COEF_W-1:0]    coef_p1_q, coef_p1_d;
  logic signed [MULTBITS-1:0]  prod_p2_q, prod_p2_d;
  logic signed [ACCUBITS-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0]    out_sample_q, out_sample_d;

  logic accept;
  logic last_drain;

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (coef_addr_q == LAST_TAP) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == LAST_DRAIN) state_d = DONE;
      DONE:    state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == DONE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign accept     = in_valid && in_ready;
  assign last_drain = (state_q == DRAIN) && (drain_cnt_q == LAST_DRAIN);
  assign coef_addr  = coef_addr_q;
  assign out_sample = out_sample_q;

  // ---------------------------------------------------------------------------
  // Sequencing: history write, read pointer and tap counter
  // ---------------------------------------------------------------------------
  // coef_addr_q doubles as the tap counter k. The read pointer starts at the
  // entry just written and walks backwards one entry per issue.
  always_comb begin
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    coef_addr_d = coef_addr_q;
    drain_cnt_d = drain_cnt_q;
    if (accept) begin
      hist_d[wr_ptr_q] = in_sample;
      wr_ptr_d         = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
      rd_ptr_d         = wr_ptr_q;
      coef_addr_d      = '0;
    end else if (state_q == RUN) begin
      drain_cnt_d = '0;
      if (coef_addr_q != LAST_TAP) begin
        coef_addr_d = coef_addr_q + AW'(1);
        rd_ptr_d    = (rd_ptr_q == '0) ? LAST_TAP : rd_ptr_q - AW'(1);
      end
    end else if (state_q == DRAIN) begin
      drain_cnt_d = drain_cnt_q + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: history read, registered in step with the ROM address register
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p0_d = (state_q == RUN);
    smp_p0_d = hist_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Stage p1: sample and the coefficient returned by the ROM
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p1_d  = vld_p0_q;
    smp_p1_d  = smp_p0_q;
    coef_p1_d = coef_data;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: signed product
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p2_d  = vld_p1_q;
    prod_p2_d = MULTBITS'(smp_p1_q) * MULTBITS'(coef_p1_q);
  end

  // ---------------------------------------------------------------------------
  // Stage p3: accumulate, then saturate into the output register
  // ---------------------------------------------------------------------------
  // The accumulator is ACCUBITS wide, so the sum of TAPS full-scale products
  // cannot wrap. The output register loads on the edge that enters DONE.
  // acc_d already holds the final product at that edge.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (vld_p2_q) begin
      acc_d = acc_q + ACCUBITS'(prod_p2_q);
    end
    out_sample_d = out_sample_q;
    if (last_drain) begin
      out_sample_d = sat_shift(acc_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers with reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      coef_addr_q  <= '0;
      drain_cnt_q  <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      acc_q        <= '0;
      out_sample_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      coef_addr_q  <= coef_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      acc_q        <= acc_d;
      out_sample_q <= out_sample_d;
      hist_q       <= hist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline data registers; the vld_pN flags above qualify them
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    smp_p0_q  <= smp_p0_d;
    smp_p1_q  <= smp_p1_d;
    coef_p1_q <= coef_p1_d;
    prod_p2_q <= prod_p2_d;
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
`timescale 1ns/1ps
module tb_fir_mac_scheduler;

  localparam int TAPS = 8;
  localparam int AW   = 3;
  localparam int LAT  = TAPS + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_sample = '0;

  logic in_ready0, busy0, out_valid0;
  logic [AW-1:0] coef_addr0;
  logic signed [15:0] coef_data0, out_sample0;
  logic in_ready15, busy15, out_valid15;
  logic [AW-1:0] coef_addr15;
  logic signed [15:0] coef_data15, out_sample15;

  logic signed [15:0] coef_mem [TAPS];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Reference state: newest sample at the front of hist_m
  int hist_m[$];
  int exp0_q[$];
  int exp15_q[$];
  int acc_t_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered coefficient ROMs
  always @(posedge clk) begin
    coef_data0  <= coef_mem[coef_addr0];
    coef_data15 <= coef_mem[coef_addr15];
  end

  fir_mac_scheduler #(.TAPS(TAPS), .MULTBITS(32), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_sample(in_sample), .coef_addr(coef_addr0), .coef_data(coef_data0),
    .busy(busy0), .out_valid(out_valid0), .out_sample(out_sample0)
  );

  fir_mac_scheduler #(.TAPS(TAPS), .MULTBITS(32), .SHIFT(15)) u_dut15 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready15),
    .in_sample(in_sample), .coef_addr(coef_addr15), .coef_data(coef_data15),
    .busy(busy15), .out_valid(out_valid15), .out_sample(out_sample15)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_reset();
    hist_m.delete();
    for (int i = 0; i < TAPS; i++) hist_m.push_back(0);
    exp0_q.delete();
    exp15_q.delete();
    acc_t_q.delete();
  endtask

  // Direct convolution y[n] = sum coef[k] * x[n-k]
  task automatic model_accept(input int s, input int t_acc);
    longint sum;
    hist_m.push_front(s);
    void'(hist_m.pop_back());
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += longint'(coef_mem[k]) * longint'(hist_m[k]);
    exp0_q.push_back(clamp16(sum));
    exp15_q.push_back(clamp16(sum >>> 15));
    acc_t_q.push_back(t_acc);
  endtask

  // Monitor: compare every out_valid pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0) begin
        checks++;
        if (exp0_q.size() == 0) begin
          failures++;
          $display("FAIL out0_unexpected: got out_valid with value %0d, required no output", out_sample0);
        end else begin
          checks--;
          chk("out0_value", out_sample0, exp0_q.pop_front());
        end
        if (acc_t_q.size() > 0) chk("out_latency", (cyc + 1) - acc_t_q.pop_front(), LAT);
      end
      if (out_valid15) begin
        checks++;
        if (exp15_q.size() == 0) begin
          failures++;
          $display("FAIL out15_unexpected: got out_valid with value %0d, required no output", out_sample15);
        end else begin
          checks--;
          chk("out15_value", out_sample15, exp15_q.pop_front());
        end
      end
    end
  end

  // Call at a negedge. Returns at the negedge after the accept edge.
  task automatic send(input int s, input bit hold, output int t_acc);
    int guard;
    guard = 0;
    in_valid  = 1'b1;
    in_sample = 16'(s);
    while (!in_ready0 && guard < 100) begin
      chk("busy_while_not_ready", busy0, 1);
      @(negedge clk);
      guard++;
    end
    if (!in_ready0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      in_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc + 1;
    model_accept(s, t_acc);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy stayed 1 for %0d cycles, required 0", guard);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready0, 1);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_out_valid"}, out_valid0, 0);
    chk({tag, "_out_sample0"}, out_sample0, 0);
    chk({tag, "_out_sample15"}, out_sample15, 0);
    chk({tag, "_coef_addr"}, coef_addr0, 0);
  endtask

  initial begin
    int t, prev_t, guard;
    model_reset();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'(k + 1);

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");

    // Impulse through coef[k]=k+1: 1..8 then zeros
    send(1, 1'b0, t);
    for (int i = 0; i < 9; i++) send(0, 1'b0, t);

    // Tap addresses on consecutive RUN cycles; a mid-RUN offer is not taken
    wait_idle();
    send(7, 1'b0, t);
    for (int k = 0; k < TAPS; k++) begin
      chk("run_coef_addr", coef_addr0, k);
      chk("run_in_ready", in_ready0, 0);
      if (k == 2) begin in_valid = 1'b1; in_sample = 16'sd99; end
      if (k == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("drain_in_ready", in_ready0, 0);
    chk("addr_hold_after_run", coef_addr0, TAPS - 1);

    // Continuous in_valid: accepts exactly TAPS+4 cycles apart
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'($urandom_range(200) - 100);
    prev_t = -1;
    for (int i = 0; i < 5; i++) begin
      send(int'($urandom_range(200)) - 100, (i != 4), t);
      if (prev_t >= 0) chk("accept_spacing", t - prev_t, LAT);
      prev_t = t;
    end

    // Saturation with full-scale samples and coefficients
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'sd32767;
    for (int i = 0; i < TAPS; i++) send(32767, 1'b0, t);
    for (int i = 0; i < TAPS; i++) send(-32768, 1'b0, t);

    // Random small-range data, many pointer wraps
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'($urandom_range(200) - 100);
    for (int i = 0; i < 25; i++) send(int'($urandom_range(200)) - 100, 1'b0, t);

    // Random full-range data
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'($urandom);
    for (int i = 0; i < 16; i++) send(int'($urandom_range(65535)) - 32768, ($urandom_range(1) == 1), t);
    in_valid = 1'b0;

    // Reset during RUN cycle 5 aborts the pass and clears the history
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 16'(k + 1);
    send(5, 1'b0, t);
    repeat (5) @(negedge clk);
    chk("abort_coef_addr", coef_addr0, 5);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    repeat (20) @(negedge clk);
    send(1, 1'b0, t);

    // Let remaining expectations drain
    guard = 0;
    while ((exp0_q.size() != 0 || exp15_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_outputs0", exp0_q.size(), 0);
    chk("pending_outputs15", exp15_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
